// File: rtl/basis_pkg.sv
// ---------------------------------------------------------------------------
// basis_pkg
// Shared definitions for the basis-function arbiter slice: default sizing,
// done-qualifier depth and the sequencer state encoding.
// ---------------------------------------------------------------------------
package basis_pkg;

    localparam int BASIS_N       = 4;    // default number of requesters
    localparam int BASIS_W       = 8;    // default operand/result width
    localparam int BASIS_TIMEOUT = 255;  // default WAIT cycle limit (8-bit)
    localparam int QUAL_LEN      = 3;    // consecutive done samples required

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_DELIVER = 2'd3
    } state_t;

endpackage

// File: rtl/basis_arbiter_done_qual.sv
// ---------------------------------------------------------------------------
// done_qual
// Qualifies a raw done line: Q is high only when the current DIN and the
// previous QUAL_LEN-1 samples taken with EN=1 since the last CLR are all high.
//
// Ports:
//   CLK  in   clock
//   RST  in   synchronous active-high reset, clears history
//   CLR  in   synchronous clear of the sample history
//   EN   in   shift DIN into the history on this edge
//   DIN  in   raw done line
//   Q    out  qualified done (combinational on DIN)
// ---------------------------------------------------------------------------
module done_qual
    import basis_pkg::*;
(
    input  logic CLK,
    input  logic RST,
    input  logic CLR,
    input  logic EN,
    input  logic DIN,
    output logic Q
);

    // Previous QUAL_LEN-1 samples; bit 0 is the most recent.
    logic [QUAL_LEN-2:0] r_hist;

    always_ff @(posedge CLK) begin
        if (RST || CLR) begin
            r_hist <= '0;
        end else if (EN) begin
            r_hist <= {r_hist[QUAL_LEN-3:0], DIN};
        end
    end

    // The live sample completes the run, so Q falls as soon as DIN drops.
    assign Q = DIN & (&r_hist);

endmodule

// File: rtl/basis_arbiter.sv
// ---------------------------------------------------------------------------
// basis_arbiter
// Round-robin arbiter/sequencer sharing one basis-function unit among N
// requesters. Latches the winner's operands, pulses U_START, waits for a
// qualified done (or timeout) and returns the result with a one-cycle RD.
//
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   REQ[N]        request levels
//   A, B[N*W]     packed operands, requester i at [i*W +: W]
//   GNT[N]        one-hot grant, ISSUE through DELIVER
//   RD[N]         one-cycle result strobe to the granted requester
//   Y[W], ERR     registered result / timeout flag, held until next DELIVER
//   U_START       one-cycle start to the shared unit
//   U_A, U_B[W]   latched operands to the unit
//   U_DONE, U_Y   raw done and result from the unit
// ---------------------------------------------------------------------------
module basis_arbiter
    import basis_pkg::*;
#(
    parameter int N       = BASIS_N,
    parameter int W       = BASIS_W,
    parameter int TIMEOUT = BASIS_TIMEOUT
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic [N-1:0]   REQ,
    input  logic [N*W-1:0] A,
    input  logic [N*W-1:0] B,
    output logic [N-1:0]   GNT,
    output logic [N-1:0]   RD,
    output logic [W-1:0]   Y,
    output logic           ERR,
    output logic           U_START,
    output logic [W-1:0]   U_A,
    output logic [W-1:0]   U_B,
    input  logic           U_DONE,
    input  logic [W-1:0]   U_Y
);

    localparam int          IW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned NU = N;

    state_t          r_state;
    state_t          w_next;
    logic [IW-1:0]   r_ptr;
    logic [IW-1:0]   r_idx;
    logic [IW-1:0]   w_pick;
    logic [N-1:0]    w_onehot;
    logic [7:0]      r_cnt;
    logic [W-1:0]    r_y;
    logic            r_err;
    logic [W-1:0]    r_ua;
    logic [W-1:0]    r_ub;
    logic            w_qual;
    logic            w_clr;
    logic            w_en;
    logic            w_timeout;

    // First set request at or above ptr, wrapping past N-1 back to 0.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0]  req,
                                              input logic [IW-1:0] ptr);
        logic [IW-1:0] sel;
        logic [IW-1:0] cand;
        logic          found;
        sel   = ptr;
        found = 1'b0;
        for (int unsigned k = 0; k < NU; k++) begin
            cand = IW'((32'(ptr) + k) % NU);
            if (!found && req[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
        return sel;
    endfunction

    assign w_pick    = rr_pick(REQ, r_ptr);
    assign w_clr     = (r_state == ST_ISSUE);
    assign w_en      = (r_state == ST_WAIT);
    assign w_timeout = (r_cnt == 8'(TIMEOUT));

    always_comb begin
        w_onehot        = '0;
        w_onehot[r_idx] = 1'b1;
    end

    done_qual u_qual (
        .CLK (CLK),
        .RST (RST),
        .CLR (w_clr),
        .EN  (w_en),
        .DIN (U_DONE),
        .Q   (w_qual)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        GNT     = '0;
        RD      = '0;
        U_START = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (|REQ) w_next = ST_ISSUE;
            end
            ST_ISSUE: begin
                U_START = 1'b1;
                GNT     = w_onehot;
                w_next  = ST_WAIT;
            end
            ST_WAIT: begin
                GNT = w_onehot;
                if (w_qual || w_timeout) w_next = ST_DELIVER;
            end
            ST_DELIVER: begin
                GNT    = w_onehot;
                RD     = w_onehot;
                w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_ptr <= '0;
            r_idx <= '0;
            r_cnt <= '0;
            r_y   <= '0;
            r_err <= 1'b0;
            r_ua  <= '0;
            r_ub  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (|REQ) begin
                        r_idx <= w_pick;
                        r_ua  <= A[w_pick*W +: W];
                        r_ub  <= B[w_pick*W +: W];
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= '0;
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + 8'd1;
                    // Qualified done takes priority over a same-edge timeout.
                    if (w_qual) begin
                        r_y   <= U_Y;
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_y   <= '0;
                        r_err <= 1'b1;
                    end
                end
                ST_DELIVER: begin
                    r_ptr <= (r_idx == IW'(N - 1)) ? '0 : r_idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign Y   = r_y;
    assign ERR = r_err;
    assign U_A = r_ua;
    assign U_B = r_ub;

endmodule

// File: doc/basis_arbiter.md
# basis_arbiter

Round-robin arbiter and sequencer that shares one basis-function compute unit among N requesters. It latches the winning requester's operands and issues a one-cycle start. It then waits for the unit's raw done line, qualified over three consecutive samples, and returns the result with a one-cycle RD strobe to the granted requester. It sits between the tree-parser operation nodes and a single shared basis unit, and bounds every operation with a timeout.

## Interface
Parameters:
- N, 4, number of requesters (2..8)
- W, 8, operand/result width
- TIMEOUT, 255, max WAIT cycles before abort (8-bit counter)

Ports:
- CLK  in  1  clock, all logic on rising edge
- RST  in  1  reset, synchronous, active-high
- REQ  in  N  per-requester request level
- A  in  N*W  operand A, requester i at bits [i*W +: W]
- B  in  N*W  operand B, same packing
- GNT  out  N  one-hot grant, held from ISSUE through DELIVER
- RD  out  N  one-cycle result-valid strobe to granted requester
- Y  out  W  result, valid while RD is high, held until next DELIVER
- ERR  out  1  high with RD when the operation timed out
- U_START  out  1  one-cycle start to shared unit
- U_A  out  W  latched operand A to unit
- U_B  out  W  latched operand B to unit
- U_DONE  in  1  raw (unqualified) done from unit
- U_Y  in  W  unit result

## Operation
- States: IDLE, ISSUE, WAIT, DELIVER.
- IDLE: if any REQ high, pick the first set bit searching from ptr upward with wraparound. Latch its index, A slice → U_A, B slice → U_B. Go to ISSUE. Otherwise stay in IDLE.
- ISSUE (1 cycle): U_START=1, GNT[idx]=1. Clear the done qualifier and the timeout counter. Go to WAIT.
- WAIT: qualifier samples U_DONE each cycle; counter increments.
  - On qualified done (U_DONE sampled high on 3 consecutive edges in WAIT): Y←U_Y, ERR←0, go to DELIVER.
  - On counter == TIMEOUT without qualified done: Y←0, ERR←1, go to DELIVER.
  - Qualified done wins if both occur on the same edge.
- DELIVER (1 cycle): RD[idx]=1, GNT[idx]=1. Set ptr←(idx+1) mod N. Go to IDLE.
- REQ dropped after grant is ignored; the operation completes and RD still pulses. The requester must drop REQ on seeing RD, or it is rearbitrated fairly behind the others.
- U_DONE high for fewer than 3 consecutive samples, or high before ISSUE, never counts: the qualifier shift register is cleared in ISSUE.
- U_A and U_B stay stable from ISSUE until the next ISSUE.

## Timing
- Reset: state=IDLE, ptr=0, GNT=0, RD=0, Y=0, ERR=0, U_START=0, U_A=0, U_B=0, qualifier=0, counter=0. RST mid-operation aborts immediately with no RD; the unit's later done is ignored.
- Latency:
  - REQ sampled at edge e0 → ISSUE after e0, with U_START and GNT high.
  - WAIT starts after e0+1.
  - If U_DONE is high at edges e0+2, e0+3 and e0+4: DELIVER after e0+4, RD high for one cycle. This minimum is 5 cycles REQ-to-RD.
  - Back-to-back: the earliest next ISSUE is 1 cycle after DELIVER, because IDLE takes one cycle.
- Timeout: ERR/RD after TIMEOUT+1 WAIT cycles measured from WAIT entry.
- Y and ERR are registered and held after DELIVER until the next DELIVER.

## Structure
- Shared package basis_pkg: state encoding constants (IDLE=0, ISSUE=1, WAIT=2, DELIVER=3), default N/W/TIMEOUT, qualifier depth constant QUAL_LEN=3.
- Sub-module done_qual: QUAL_LEN-deep sampler with inputs CLK, RST, CLR, EN, DIN and output Q.
  - Q=1 when the current sample and the previous QUAL_LEN-1 samples (all taken with EN=1 since the last CLR) are high.
  - Q drops combinationally when DIN=0.
- Round-robin pick is a combinational function inside basis_arbiter.

## Test plan
- Single request: REQ=0001, A0=8'h12, B0=8'h34, U_DONE high 3 cycles after start with U_Y=8'h46 → U_START once, U_A=12/U_B=34, RD=0001 for 1 cycle 5 cycles after REQ, Y=8'h46, ERR=0.
- Fairness: REQ=1111 held, unit answers each start after 3 cycles → grant order 0,1,2,3,0. Each RD is one-hot and matches the prior GNT.
- Glitch rejection: U_DONE pattern 1,1,0,1,1,1 in WAIT → RD only after the third consecutive 1, and Y equals U_Y at that edge.
- Timeout: TIMEOUT=10, U_DONE held 0 → RD and ERR high exactly 11 WAIT cycles after WAIT entry, Y=0, next request then serviced normally.
- Reset mid-WAIT: assert RST for 1 cycle during WAIT, then U_DONE held high → no RD, all outputs 0, ptr=0. A new REQ=0100 is granted to requester 2.
- Stale done: U_DONE already high before REQ=0010 → U_START issued, and RD occurs no earlier than 3 WAIT samples later.
